io_handshake_port: RTL and testbench
====================================

Name: io_handshake_port

Overview:
Peripheral-side partner of the processor's byte I/O port (bus_out/hs_out out of the core, bus_in/hs_in into it). It answers the processor's four-phase handshake. On OUT it captures bus_out into an RX FIFO; on IN it presents the next byte from a TX FIFO on bus_in. The host or testbench side exchanges bytes through simple valid/ready FIFO ports. It sits outside Processor and connects pin-for-pin to its I/O ports, plus the io_dir line from the controller.

Parameters:
WIDTH, 8, data byte width (matches bus_in/bus_out)
DEPTH, 4, entries per FIFO; power of two, >= 2
CW, 3, count width = log2(DEPTH)+1

Ports:
g_clk  input  1  system clock, all state on rising edge
g_clr  input  1  global clear, asynchronous, active-low
bus_out  input  WIDTH  processor output data (R_OUT)
hs_out  input  1  processor request strobe
io_dir  input  1  processor transfer direction, sampled with hs_out: 0 = OUT (processor writes), 1 = IN (processor reads)
bus_in  output  WIDTH  data to processor RIN, registered
hs_in  output  1  acknowledge to processor, registered
rx_data  output  WIDTH  RX FIFO head
rx_valid  output  1  RX FIFO not empty
rx_ready  input  1  host pops RX head when rx_valid & rx_ready
tx_data  input  WIDTH  host byte for processor
tx_valid  input  1  host push request
tx_ready  output  1  TX FIFO not full; push occurs on tx_valid & tx_ready
rx_count  output  CW  RX occupancy 0..DEPTH
tx_count  output  CW  TX occupancy 0..DEPTH
proto_err  output  1  one-cycle pulse on handshake violation

Behaviour:
- Reset (g_clr low, asynchronous): state IDLE, hs_in=0, bus_in=0, both FIFOs empty, rx_valid=0, tx_ready=1, counts=0, proto_err=0. hs_in drops immediately even mid-handshake. An in-flight byte is discarded.
- FSM states: IDLE, SETUP, ACK. hs_in=1 only in ACK.
- IDLE, hs_out=1, io_dir=0:
  - If RX not full: push bus_out, go to ACK.
  - If RX full: stay in IDLE; hs_in stays low and the processor stalls. Fullness is evaluated before any same-cycle host pop, with no pass-through.
- IDLE, hs_out=1, io_dir=1:
  - If TX not empty: load bus_in with the TX head, pop it, go to SETUP.
  - If TX empty: stay in IDLE (stall).
- SETUP: one cycle with bus_in stable and hs_in=0 (data setup before ack); then go to ACK.
- ACK: hold hs_in=1 and bus_in until hs_out=0 is sampled, then go to IDLE. hs_in clears on that same edge.
- Latency:
  - OUT: hs_out sampled high at edge k gives hs_in=1 after edge k (visible cycle k+1).
  - IN: hs_in=1 one cycle later, after edge k+1.
  - The next request is accepted no earlier than the edge after returning to IDLE.
- Violation: hs_out low while in SETUP. The byte counts as delivered, proto_err pulses, and the FSM still goes to ACK, then to IDLE on the next edge.
- io_dir is ignored outside IDLE.
- bus_in holds its last value between IN transfers.
- FIFOs:
  - Circular buffers with separate read/write pointers; pointers wrap modulo DEPTH.
  - count = pushes - pops, range 0..DEPTH.
  - Push and pop in the same cycle are allowed when not full/empty: count is unchanged and pointers advance.
  - Push when full and pop when empty are ignored, with no state change.
  - rx_data is valid combinationally whenever rx_valid=1.
- Host TX push and processor IN pop may coincide. With TX count=1 that is legal; the pushed byte lands behind the popped one.

Decomposition:
- Package io_port_pkg: state encoding (IDLE=2'd0, SETUP=2'd1, ACK=2'd2), direction constants DIR_OUT=0 and DIR_IN=1, default WIDTH/DEPTH.
- One sub-module io_fifo (WIDTH, DEPTH) instantiated twice, for RX and TX. It provides push, pop, data in/out, full, empty, count. The FSM and bus_in/hs_in registers live in the top.

Test Plan:
- Reset then single OUT:
  - Stimulus: bus_out=8'hA5, io_dir=0, hs_out=1.
  - Response: hs_in=1 after next edge; rx_count=1, rx_data=A5. hs_out=0 then hs_in=0 next edge. Pop with rx_ready gives rx_count=0.
- IN with data:
  - Stimulus: host pushes 8'h3C, 8'h7E; processor does two IN handshakes.
  - Response: bus_in=3C, stable one cycle before hs_in rises. Second transfer gives 7E; tx_count goes 2→1→0.
- Stall on empty/full:
  - IN with TX empty: hs_in stays 0 for 10 cycles; push 8'h11; hs_in rises 2 cycles later with bus_in=11.
  - OUT with RX full (4 entries): stalls until one rx pop; then the byte is captured and rx_count=4.
- Wrap-around:
  - Stimulus: 10 OUT bytes 8'h00..8'h09 interleaved with pops.
  - Response: FIFO order preserved across pointer wrap; no loss or duplication.
- Violation:
  - Stimulus: drop hs_out during SETUP.
  - Response: proto_err one-cycle pulse; tx_count decremented; FSM back in IDLE within 2 cycles.
- Async reset mid-ACK:
  - Stimulus: g_clr low between edges while in ACK.
  - Response: hs_in=0 and counts=0 immediately; after release, a normal OUT of 8'h5A succeeds.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared types and constants for the processor-side byte I/O port.
// Holds the handshake state encoding, direction codes and default sizes.
package io_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Count width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Circular-buffer FIFO used for both the RX and TX byte queues.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty, count.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the pre-edge count: no pass-through either way.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/io_handshake_port.sv
// Peripheral side of the processor's four-phase byte I/O handshake.
// Ports: processor pins (bus_out, hs_out, io_dir, bus_in, hs_in),
// host RX pop port (rx_*), host TX push port (tx_*), counts, proto_err.
module io_handshake_port
    import io_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic [WIDTH-1:0] bus_out,
    input  logic             hs_out,
    input  logic             io_dir,
    output logic [WIDTH-1:0] bus_in,
    output logic             hs_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [CW-1:0]    rx_count,
    output logic [CW-1:0]    tx_count,
    output logic             proto_err
);

    state_t           state_q;
    state_t           state_d;
    logic             rx_push;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic [WIDTH-1:0] tx_head;
    logic [WIDTH-1:0] bus_in_q;
    logic             hs_in_q;
    logic             err_d;
    logic             err_q;

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clk   (g_clk),
        .rst_n (g_clr),
        .push  (rx_push),
        .wdata (bus_out),
        .pop   (rx_ready),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clk   (g_clk),
        .rst_n (g_clr),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign rx_valid  = ~rx_empty;
    assign tx_ready  = ~tx_full;
    assign bus_in    = bus_in_q;
    assign hs_in     = hs_in_q;
    assign proto_err = err_q;

    // A request that cannot be served simply leaves us in IDLE,
    // which is what stalls the processor.
    always_comb begin
        state_d = state_q;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs_out) begin
                    if (io_dir == DIR_OUT) begin
                        if (!rx_full) begin
                            rx_push = 1'b1;
                            state_d = ACK;
                        end
                    end else if (!tx_empty) begin
                        tx_pop  = 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                // Byte already left the TX FIFO; an early
                // release is flagged but the cycle completes.
                err_d   = ~hs_out;
                state_d = ACK;
            end
            ACK: begin
                if (!hs_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q  <= IDLE;
            hs_in_q  <= 1'b0;
            bus_in_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_in_q <= (state_d == ACK);
            err_q   <= err_d;
            if (tx_pop) begin
                bus_in_q <= tx_head;
            end
        end
    end

endmodule

// File: tb/tb_io_handshake_port.sv
// Self-checking bench for io_handshake_port: directed handshake
// scenarios plus randomized traffic against a queue-based model.
module tb_io_handshake_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             g_clk;
    logic             g_clr;
    logic [WIDTH-1:0] bus_out;
    logic             hs_out;
    logic             io_dir;
    logic [WIDTH-1:0] bus_in;
    logic             hs_in;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [CW-1:0]    rx_count;
    logic [CW-1:0]    tx_count;
    logic             proto_err;

    io_handshake_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .bus_out   (bus_out),
        .hs_out    (hs_out),
        .io_dir    (io_dir),
        .bus_in    (bus_in),
        .hs_in     (hs_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .proto_err (proto_err)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: two byte queues plus handshake flags.
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    logic [7:0] m_bus   = 8'h00;
    bit         m_hs    = 1'b0;
    bit         m_err   = 1'b0;
    bit         m_setup = 1'b0;
    int         rx_n;
    int         tx_n;
    bit         m_rxpush;
    bit         m_txpop;

    always @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            m_rx.delete();
            m_tx.delete();
            m_bus   = 8'h00;
            m_hs    = 1'b0;
            m_err   = 1'b0;
            m_setup = 1'b0;
        end else begin
            rx_n     = m_rx.size();
            tx_n     = m_tx.size();
            m_rxpush = 1'b0;
            m_txpop  = 1'b0;
            m_err    = 1'b0;
            if (m_setup) begin
                m_err   = !hs_out;
                m_setup = 1'b0;
                m_hs    = 1'b1;
            end else if (m_hs) begin
                if (!hs_out) m_hs = 1'b0;
            end else if (hs_out) begin
                if (!io_dir) begin
                    if (rx_n < DEPTH) begin
                        m_rxpush = 1'b1;
                        m_hs     = 1'b1;
                    end
                end else if (tx_n > 0) begin
                    m_bus   = m_tx[0];
                    m_txpop = 1'b1;
                    m_setup = 1'b1;
                end
            end
            if (rx_ready && rx_n > 0) m_rx.delete(0);
            if (m_rxpush) m_rx.push_back(bus_out);
            if (m_txpop) m_tx.delete(0);
            if (tx_valid && tx_n < DEPTH) m_tx.push_back(tx_data);
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge g_clk) begin
        if (cmp_en) begin
            chk("m_hs_in", hs_in, m_hs);
            chk("m_bus_in", bus_in, m_bus);
            chk("m_proto_err", proto_err, m_err);
            chk("m_rx_valid", rx_valid, m_rx.size() > 0);
            chk("m_tx_ready", tx_ready, m_tx.size() < DEPTH);
            chk("m_rx_count", rx_count, m_rx.size());
            chk("m_tx_count", tx_count, m_tx.size());
            if (m_rx.size() > 0) chk("m_rx_data", rx_data, m_rx[0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge g_clk);
            #2;
        end
    endtask

    task automatic wait_hs(input logic v, input int budget,
                           input string nm);
        int i = 0;
        while (hs_in !== v && i < budget) begin
            cyc(1);
            i++;
        end
        chk(nm, hs_in, v);
    endtask

    task automatic proc_out(input logic [7:0] b);
        bus_out = b;
        io_dir  = 1'b0;
        hs_out  = 1'b1;
        wait_hs(1'b1, 50, "out_ack");
        hs_out = 1'b0;
        wait_hs(1'b0, 5, "out_rel");
    endtask

    task automatic proc_in(output logic [7:0] b);
        io_dir = 1'b1;
        hs_out = 1'b1;
        wait_hs(1'b1, 50, "in_ack");
        b      = bus_in;
        hs_out = 1'b0;
        wait_hs(1'b0, 5, "in_rel");
    endtask

    task automatic host_push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic host_pop();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    logic [7:0] b;
    logic [7:0] exp4 [4];

    initial begin
        g_clr    = 1'b1;
        bus_out  = '0;
        hs_out   = 1'b0;
        io_dir   = 1'b0;
        rx_ready = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        #1 g_clr = 1'b0;
        #20 g_clr = 1'b1;
        cmp_en = 1'b1;
        cyc(1);

        chk("rst_hs_in", hs_in, 1'b0);
        chk("rst_bus_in", bus_in, 8'h00);
        chk("rst_rx_count", rx_count, 3'd0);
        chk("rst_tx_count", tx_count, 3'd0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);

        // Single OUT
        bus_out = 8'hA5;
        io_dir  = 1'b0;
        hs_out  = 1'b1;
        cyc(1);
        chk("out1_hs_in", hs_in, 1'b1);
        chk("out1_rx_count", rx_count, 3'd1);
        chk("out1_rx_data", rx_data, 8'hA5);
        hs_out = 1'b0;
        cyc(1);
        chk("out1_hs_drop", hs_in, 1'b0);
        host_pop();
        chk("out1_popped", rx_count, 3'd0);

        // IN with data
        host_push(8'h3C);
        host_push(8'h7E);
        chk("in_tx_count2", tx_count, 3'd2);
        io_dir = 1'b1;
        hs_out = 1'b1;
        cyc(1);
        chk("in_setup_bus", bus_in, 8'h3C);
        chk("in_setup_hs", hs_in, 1'b0);
        chk("in_tx_count1", tx_count, 3'd1);
        cyc(1);
        chk("in_ack_hs", hs_in, 1'b1);
        chk("in_ack_bus", bus_in, 8'h3C);
        hs_out = 1'b0;
        cyc(1);
        chk("in_rel_hs", hs_in, 1'b0);
        proc_in(b);
        chk("in_second", b, 8'h7E);
        chk("in_tx_count0", tx_count, 3'd0);

        // Stall on empty TX
        io_dir = 1'b1;
        hs_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("stall_empty_hs", hs_in, 1'b0);
        end
        host_push(8'h11);
        chk("stall_push_cnt", tx_count, 3'd1);
        chk("stall_push_hs", hs_in, 1'b0);
        cyc(1);
        chk("stall_setup_hs", hs_in, 1'b0);
        cyc(1);
        chk("stall_ack_hs", hs_in, 1'b1);
        chk("stall_bus", bus_in, 8'h11);
        hs_out = 1'b0;
        cyc(1);

        // Stall on full RX
        for (int i = 0; i < 4; i++) proc_out(8'hC0 + 8'(i));
        chk("full_rx_count", rx_count, 3'd4);
        bus_out = 8'hD0;
        io_dir  = 1'b0;
        hs_out  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_full_hs", hs_in, 1'b0);
        end
        host_pop();
        chk("full_pop_cnt", rx_count, 3'd3);
        chk("full_pop_hs", hs_in, 1'b0);
        chk("full_pop_head", rx_data, 8'hC1);
        cyc(1);
        chk("full_cap_hs", hs_in, 1'b1);
        chk("full_cap_cnt", rx_count, 3'd4);
        hs_out = 1'b0;
        cyc(1);
        exp4[0] = 8'hC1;
        exp4[1] = 8'hC2;
        exp4[2] = 8'hC3;
        exp4[3] = 8'hD0;
        for (int i = 0; i < 4; i++) begin
            chk("full_drain", rx_data, exp4[i]);
            host_pop();
        end

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            proc_out(8'(i));
            if (i % 2 == 1) begin
                chk("wrap_a", rx_data, 8'(i - 1));
                host_pop();
                chk("wrap_b", rx_data, 8'(i));
                host_pop();
            end
        end
        chk("wrap_empty", rx_count, 3'd0);

        // Violation: release during SETUP
        host_push(8'h99);
        io_dir = 1'b1;
        hs_out = 1'b1;
        cyc(1);
        chk("viol_setup_hs", hs_in, 1'b0);
        chk("viol_tx_count", tx_count, 3'd0);
        hs_out = 1'b0;
        cyc(1);
        chk("viol_err", proto_err, 1'b1);
        chk("viol_ack", hs_in, 1'b1);
        chk("viol_bus", bus_in, 8'h99);
        cyc(1);
        chk("viol_err_clr", proto_err, 1'b0);
        chk("viol_idle", hs_in, 1'b0);

        // Async reset mid-ACK
        host_push(8'h44);
        bus_out = 8'h77;
        io_dir  = 1'b0;
        hs_out  = 1'b1;
        cyc(1);
        chk("arst_pre_hs", hs_in, 1'b1);
        #2 g_clr = 1'b0;
        #1;
        chk("arst_hs", hs_in, 1'b0);
        chk("arst_rx_cnt", rx_count, 3'd0);
        chk("arst_tx_cnt", tx_count, 3'd0);
        hs_out = 1'b0;
        cyc(1);
        g_clr = 1'b1;
        cyc(1);
        proc_out(8'h5A);
        chk("arst_out_data", rx_data, 8'h5A);
        chk("arst_out_cnt", rx_count, 3'd1);
        host_pop();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) hs_out = ~hs_out;
            if ($urandom_range(0, 99) < 40) io_dir = 1'($urandom);
            bus_out  = 8'($urandom);
            tx_data  = 8'($urandom);
            tx_valid = ($urandom_range(0, 99) < 45);
            rx_ready = ($urandom_range(0, 99) < 40);
            cyc(1);
        end
        hs_out   = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
